fetch_queue: RTL and testbench

Instruction prefetch buffer between the program counter / instruction memory and the decode stage. Each cycle it captures the current {PC, instruction} pair into a small FIFO and presents the oldest pair to decode with a valid/ready handshake. When the FIFO is full it raises `keep_o`, which drives the program counter's hold input so the fetched PC is re-presented rather than lost. A taken branch or jump flushes all buffered entries in one cycle.

---
 rtl/fetch_queue_pkg.sv | 9 +
 rtl/fetch_queue_ram.sv | 24 ++
 rtl/fetch_queue.sv | 72 +++++++
 tb/tb_fetch_queue.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU-wide constants for the fetch path: datapath width, instruction width, NOP encoding.
// Decode substitutes NOP whenever the fetch queue presents no valid entry.
package fetch_queue_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x W register array for fetch_queue: synchronous write, asynchronous read.
// Storage is deliberately not reset; validity is tracked by the owner's pointers and count.
module fetch_queue_ram #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdat,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdat
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO of {pc, instr}; an entry written at edge N is at the head after edge N.
// When full, keep_o holds the PC so it is re-presented; flush empties the queue in one cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = fetch_queue_pkg::DATA_W,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              fetch_valid_i,
  input  logic              flush_i,
  output logic              keep_o,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [DATA_W-1:0] deq_pc_o,
  output logic [DATA_W-1:0] deq_instr_o,
  output logic [CW-1:0]     count_o
);

  logic [AW-1:0]       wp, rp;
  logic [CW-1:0]       count;
  logic [2*DATA_W-1:0] rd_dat;
  logic                full, empty, enq, deq;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign enq   = fetch_valid_i & ~full & ~flush_i;
  assign deq   = deq_valid_o & deq_ready_i;

  // keep_o must not see deq_ready_i: the PC is released only after the dequeue edge.
  assign keep_o = full & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (enq) wp <= wp + 1'b1;
      if (deq) rp <= rp + 1'b1;
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .W     (2*DATA_W)
  ) u_ram (
    .clk_i (clk_i),
    .we    (enq),
    .waddr (wp),
    .wdat  ({pc_i, instr_i}),
    .raddr (rp),
    .rdat  (rd_dat)
  );

  assign deq_valid_o = ~empty;
  assign deq_pc_o    = empty ? '0 : rd_dat[2*DATA_W-1:DATA_W];
  assign deq_instr_o = empty ? '0 : rd_dat[DATA_W-1:0];
  assign count_o     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill/hold, release, streaming wrap, flush, async reset.
module tb_fetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_i, instr_i;
  logic        fetch_valid_i, flush_i, deq_ready_i;
  logic        keep_o, deq_valid_o;
  logic [31:0] deq_pc_o, deq_instr_o;
  logic [2:0]  count_o;

  int checks   = 0;
  int failures = 0;

  fetch_queue #(.DEPTH(4), .DATA_W(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .pc_i          (pc_i),
    .instr_i       (instr_i),
    .fetch_valid_i (fetch_valid_i),
    .flush_i       (flush_i),
    .keep_o        (keep_o),
    .deq_valid_o   (deq_valid_o),
    .deq_ready_i   (deq_ready_i),
    .deq_pc_o      (deq_pc_o),
    .deq_instr_o   (deq_instr_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fetch_valid_i = 1'b1;
    pc_i          = pc;
    instr_i       = ins_of(pc);
  endtask

  logic [31:0] drain_exp [4];

  initial begin
    rst_i = 1'b0; pc_i = '0; instr_i = '0;
    fetch_valid_i = 1'b0; flush_i = 1'b0; deq_ready_i = 1'b0;

    // 1. reset held with clock running, then released
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_count", 32'(count_o), 32'd0);
      chk("rst_valid", 32'(deq_valid_o), 32'd0);
      chk("rst_keep",  32'(keep_o), 32'd0);
      chk("rst_pc",    deq_pc_o, 32'd0);
    end
    rst_i = 1'b1;
    tick();
    chk("post_rst_count", 32'(count_o), 32'd0);
    chk("post_rst_valid", 32'(deq_valid_o), 32'd0);
    chk("post_rst_keep",  32'(keep_o), 32'd0);
    chk("post_rst_instr", deq_instr_o, 32'd0);

    // 2. fill to full with no dequeue
    for (int i = 0; i < 4; i++) begin
      fetch(32'(4*i));
      tick();
      chk("fill_count", 32'(count_o), 32'(i+1));
      chk("fill_head",  deq_pc_o, 32'h00);
    end
    chk("full_keep", 32'(keep_o), 32'd1);
    fetch(32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_count", 32'(count_o), 32'd4);
      chk("hold_head",  deq_pc_o, 32'h00);
      chk("hold_keep",  32'(keep_o), 32'd1);
    end
    chk("hold_instr", deq_instr_o, ins_of(32'h00));

    // 3. release from full: one dequeue, then 0x10 enters at the following edge
    deq_ready_i = 1'b1;
    tick();
    chk("rel_keep",  32'(keep_o), 32'd0);
    chk("rel_count", 32'(count_o), 32'd3);
    chk("rel_head",  deq_pc_o, 32'h04);
    deq_ready_i = 1'b0;
    tick();
    chk("rel_enq_count", 32'(count_o), 32'd4);
    chk("rel_enq_keep",  32'(keep_o), 32'd1);
    fetch_valid_i = 1'b0;
    deq_ready_i   = 1'b1;
    drain_exp[0] = 32'h04; drain_exp[1] = 32'h08;
    drain_exp[2] = 32'h0C; drain_exp[3] = 32'h10;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc",    deq_pc_o, drain_exp[k]);
      chk("drain_instr", deq_instr_o, ins_of(drain_exp[k]));
      tick();
    end
    chk("drain_empty_count", 32'(count_o), 32'd0);
    chk("drain_empty_valid", 32'(deq_valid_o), 32'd0);

    // 4. streaming 20 sequential PCs with decode always ready
    for (int i = 0; i < 20; i++) begin
      fetch(32'h100 + 32'(4*i));
      tick();
      chk("stream_pc",    deq_pc_o, 32'h100 + 32'(4*i));
      chk("stream_count", 32'(count_o), 32'd1);
      chk("stream_valid", 32'(deq_valid_o), 32'd1);
    end
    chk("stream_instr", deq_instr_o, ins_of(32'h14C));
    fetch_valid_i = 1'b0;
    tick();
    chk("stream_end_count", 32'(count_o), 32'd0);

    // 5. flush with 3 queued, coincident fetch and dequeue handshake
    deq_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch(32'h200 + 32'(4*i));
      tick();
    end
    chk("pre_flush_count", 32'(count_o), 32'd3);
    fetch(32'h40);
    flush_i = 1'b1; deq_ready_i = 1'b1;
    tick();
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(deq_valid_o), 32'd0);
    chk("flush_pc",    deq_pc_o, 32'd0);
    flush_i = 1'b0; deq_ready_i = 1'b0;
    fetch(32'h80);
    tick();
    chk("target_count", 32'(count_o), 32'd1);
    chk("target_pc",    deq_pc_o, 32'h80);
    chk("target_instr", deq_instr_o, ins_of(32'h80));

    // flush while full: keep_o drops combinationally so the PC can load the target
    for (int i = 1; i < 4; i++) begin
      fetch(32'h80 + 32'(4*i));
      tick();
    end
    chk("full2_keep", 32'(keep_o), 32'd1);
    fetch_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_full_keep", 32'(keep_o), 32'd0);
    tick();
    chk("flush_full_count", 32'(count_o), 32'd0);
    flush_i = 1'b0;

    // 6. asynchronous reset between edges with 2 entries queued
    for (int i = 0; i < 2; i++) begin
      fetch(32'h300 + 32'(4*i));
      tick();
    end
    fetch_valid_i = 1'b0;
    chk("pre_arst_count", 32'(count_o), 32'd2);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_valid", 32'(deq_valid_o), 32'd0);
    chk("arst_count", 32'(count_o), 32'd0);
    chk("arst_pc",    deq_pc_o, 32'd0);
    tick();
    rst_i = 1'b1;
    tick();
    chk("after_arst_count", 32'(count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
